// File: rtl/csr_counter_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter_writer_if
//  Description : CSR write request channel (valid/ready, target select, data)
//                between the SYSTEM execute unit and the counter writer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_counter_writer_if #(
    parameter int DATA_SIZE = 32
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [2:0]           wr_sel;
    logic [DATA_SIZE-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_sel,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_sel,
        input  wr_data,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/csr_counter_writer.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter_writer
//  Description : Owns the 64-bit cycle/time/instret/timecmp registers, accepts
//                32-bit CSR writes (high half staged in a shadow register and
//                committed atomically with the low half) and raises a
//                registered timer interrupt when time >= timecmp.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_counter_writer #(
    parameter int TIME_CNT_PER = 1024,
    parameter int DATA_SIZE    = 32
) (
    input  logic                   i_aclk,
    input  logic                   i_areset,
    csr_counter_writer_if.slave    wr,
    input  logic                   i_retire,
    output logic [2*DATA_SIZE-1:0] o_cycle,
    output logic [2*DATA_SIZE-1:0] o_time,
    output logic [2*DATA_SIZE-1:0] o_instret,
    output logic [2*DATA_SIZE-1:0] o_timecmp,
    output logic                   o_hi_pending,
    output logic                   o_timer_irq
);

    localparam int                 c_CNT_W   = 2 * DATA_SIZE;
    localparam int                 c_SUB_W   = $clog2(TIME_CNT_PER);
    localparam logic [c_SUB_W-1:0] c_SUB_MAX = c_SUB_W'(TIME_CNT_PER - 1);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_HI_PEND = 1'b1;

    // Register index: wr_sel[2:1]
    localparam int c_IDX_CYCLE   = 0;
    localparam int c_IDX_TIME    = 1;
    localparam int c_IDX_INSTRET = 2;
    localparam int c_IDX_TIMECMP = 3;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [1:0]           r_target;
    logic [1:0]           w_target_nxt;
    logic [DATA_SIZE-1:0] r_shadow;
    logic [DATA_SIZE-1:0] w_shadow_nxt;

    logic                 r_ready;
    logic                 r_irq;
    logic [c_CNT_W-1:0]   r_cycle;
    logic [c_CNT_W-1:0]   r_time;
    logic [c_CNT_W-1:0]   r_instret;
    logic [c_CNT_W-1:0]   r_timecmp;
    logic [c_SUB_W-1:0]   r_subtime;

    logic                 w_accept;
    logic                 w_hi_wr;
    logic [1:0]           w_wr_tgt;
    logic [3:0]           w_load_full;
    logic [3:0]           w_load_low;
    logic                 w_tick;

    assign w_accept    = wr.wr_valid && r_ready;
    assign w_hi_wr     = wr.wr_sel[0];
    assign w_wr_tgt    = wr.wr_sel[2:1];
    assign w_tick      = (r_subtime == c_SUB_MAX);
    assign wr.wr_ready = r_ready;

    // Written value wins over the increment; a low-only write keeps the old
    // upper half and drops whatever carry the increment would have produced.
    function automatic logic [c_CNT_W-1:0] f_next(
        input logic [c_CNT_W-1:0]   cur,
        input logic                 load_full,
        input logic                 load_low,
        input logic                 inc,
        input logic [DATA_SIZE-1:0] hi,
        input logic [DATA_SIZE-1:0] lo
    );
        if (load_full)
            return {hi, lo};
        else if (load_low)
            return {cur[c_CNT_W-1:DATA_SIZE], lo};
        else if (inc)
            return cur + c_CNT_W'(1);
        else
            return cur;
    endfunction

    // Write FSM state register: pending-high flag, its target and shadow data
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state  <= c_ST_IDLE;
            r_target <= 2'd0;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    // Write FSM next state: high writes (re)arm the shadow, low writes close it
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_shadow_nxt = r_shadow;
        if (w_accept) begin
            if (w_hi_wr) begin
                w_state_nxt  = c_ST_HI_PEND;
                w_target_nxt = w_wr_tgt;
                w_shadow_nxt = wr.wr_data;
            end else begin
                w_state_nxt  = c_ST_IDLE;
            end
        end
    end

    // Write FSM outputs: decode a low write into a full commit or low-only load
    always_comb begin
        w_load_full  = 4'b0000;
        w_load_low   = 4'b0000;
        o_hi_pending = (r_state == c_ST_HI_PEND);
        if (w_accept && !w_hi_wr) begin
            if ((r_state == c_ST_HI_PEND) && (r_target == w_wr_tgt))
                w_load_full[w_wr_tgt] = 1'b1;
            else
                w_load_low[w_wr_tgt]  = 1'b1;
        end
    end

    // Ready: rises on the first edge after reset, drops one cycle after a low write
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset)
            r_ready <= 1'b0;
        else
            r_ready <= !(w_accept && !w_hi_wr);
    end

    // Architectural counters and compare register
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_cycle   <= '0;
            r_time    <= '0;
            r_instret <= '0;
            r_timecmp <= '1;
        end else begin
            r_cycle   <= f_next(r_cycle, w_load_full[c_IDX_CYCLE],
                                w_load_low[c_IDX_CYCLE], 1'b1, r_shadow, wr.wr_data);
            r_time    <= f_next(r_time, w_load_full[c_IDX_TIME],
                                w_load_low[c_IDX_TIME], w_tick, r_shadow, wr.wr_data);
            r_instret <= f_next(r_instret, w_load_full[c_IDX_INSTRET],
                                w_load_low[c_IDX_INSTRET], i_retire, r_shadow, wr.wr_data);
            r_timecmp <= f_next(r_timecmp, w_load_full[c_IDX_TIMECMP],
                                w_load_low[c_IDX_TIMECMP], 1'b0, r_shadow, wr.wr_data);
        end
    end

    // Sub-tick prescaler; a TIME write restarts it so the next tick is a full period away
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset)
            r_subtime <= '0;
        else if (w_load_full[c_IDX_TIME] || w_load_low[c_IDX_TIME])
            r_subtime <= '0;
        else
            r_subtime <= r_subtime + c_SUB_W'(1);
    end

    // Timer interrupt, registered compare of the current register values
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset)
            r_irq <= 1'b0;
        else
            r_irq <= (r_time >= r_timecmp);
    end

    assign o_cycle     = r_cycle;
    assign o_time      = r_time;
    assign o_instret   = r_instret;
    assign o_timecmp   = r_timecmp;
    assign o_timer_irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_csr_counter_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_counter_writer
//  Description : Self-checking bench for csr_counter_writer. The reference
//                model describes each counter as "value last written plus
//                elapsed edges / ticks / retirements since then".
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_counter_writer;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retire = 1'b0;
    logic [63:0] cycle, tim, instret, timecmp;
    logic        hi_pending, irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_counter_writer_if #(.DATA_SIZE(32)) ifc ();

    csr_counter_writer #(
        .TIME_CNT_PER (P),
        .DATA_SIZE    (32)
    ) dut (
        .i_aclk       (clk),
        .i_areset     (rst),
        .wr           (ifc.slave),
        .i_retire     (retire),
        .o_cycle      (cycle),
        .o_time       (tim),
        .o_instret    (instret),
        .o_timecmp    (timecmp),
        .o_hi_pending (hi_pending),
        .o_timer_irq  (irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint unsigned edge_n, cyc_ref, tim_ref, ret_cnt;
    logic [63:0]     cyc_base, tim_base, ins_base, m_cmp;
    logic            m_pend, m_ready, m_irq;
    logic [1:0]      m_tgt;
    logic [31:0]     m_shadow;
    logic [63:0]     s_pc, s_pt, s_pi, s_pcmp, s_nv;
    logic            s_acc;
    logic [1:0]      s_t;

    function automatic logic [63:0] m_cycle();
        return cyc_base + (edge_n - cyc_ref);
    endfunction
    function automatic logic [63:0] m_time();
        return tim_base + (edge_n - tim_ref) / 64'(P);
    endfunction
    function automatic logic [63:0] m_instret();
        return ins_base + ret_cnt;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_n = 0; cyc_ref = 0; tim_ref = 0; ret_cnt = 0;
            cyc_base = '0; tim_base = '0; ins_base = '0; m_cmp = '1;
            m_pend = 1'b0; m_ready = 1'b0; m_irq = 1'b0;
            m_tgt = 2'd0; m_shadow = '0;
        end else begin
            s_pc   = m_cycle();
            s_pt   = m_time();
            s_pi   = m_instret();
            s_pcmp = m_cmp;
            s_acc  = ifc.wr_valid && m_ready;
            s_t    = ifc.wr_sel[2:1];
            edge_n = edge_n + 1;
            if (retire) ret_cnt = ret_cnt + 1;
            if (s_acc && ifc.wr_sel[0]) begin
                m_pend   = 1'b1;
                m_tgt    = s_t;
                m_shadow = ifc.wr_data;
            end else if (s_acc) begin
                case (s_t)
                    2'd0:    s_nv = s_pc;
                    2'd1:    s_nv = s_pt;
                    2'd2:    s_nv = s_pi;
                    default: s_nv = s_pcmp;
                endcase
                if (m_pend && m_tgt == s_t) s_nv = {m_shadow, ifc.wr_data};
                else                         s_nv = {s_nv[63:32], ifc.wr_data};
                case (s_t)
                    2'd0:    begin cyc_base = s_nv; cyc_ref = edge_n; end
                    2'd1:    begin tim_base = s_nv; tim_ref = edge_n; end
                    2'd2:    begin ins_base = s_nv; ret_cnt = 0;      end
                    default: m_cmp = s_nv;
                endcase
                m_pend = 1'b0;
            end
            m_irq   = (s_pt >= s_pcmp);
            m_ready = !(s_acc && !ifc.wr_sel[0]);
        end
    end

    // Compare every cycle, on the inactive edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("cycle",      cycle,        m_cycle());
            chk("time",       tim,          m_time());
            chk("instret",    instret,      m_instret());
            chk("timecmp",    timecmp,      m_cmp);
            chk("hi_pending", hi_pending,   m_pend);
            chk("timer_irq",  irq,          m_irq);
            chk("wr_ready",   ifc.wr_ready, m_ready);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present a write and hold it until accepted; returns 1 ns after the accept edge
    task automatic wr(input logic [2:0] sel, input logic [31:0] data);
        bit acc = 1'b0;
        int n   = 0;
        ifc.wr_valid = 1'b1;
        ifc.wr_sel   = sel;
        ifc.wr_data  = data;
        while (!acc && n < 10) begin
            acc = ifc.wr_ready;
            step();
            n++;
        end
        ifc.wr_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: sel %0d never accepted within %0d cycles", sel, n);
        end
    endtask

    initial begin
        ifc.wr_valid = 1'b0;
        ifc.wr_sel   = 3'd0;
        ifc.wr_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle counting after reset
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) chk("ready_first_edge", ifc.wr_ready, 1);
            if (i == 3) chk("time_edge3", tim, 0);
            if (i == 4) chk("time_edge4", tim, 1);
            if (i == 7) chk("time_edge7", tim, 1);
            if (i == 8) chk("time_edge8", tim, 2);
            if (i == 9) chk("time_edge9", tim, 2);
        end
        chk("cycle_10",      cycle,   64'd10);
        chk("instret_idle",  instret, 64'd0);
        chk("timecmp_reset", timecmp, '1);
        chk("irq_idle",      irq,     0);

        // Atomic 64-bit cycle write
        wr(3'd1, 32'h0000_0001);
        chk("pending_after_cycleh", hi_pending, 1);
        wr(3'd0, 32'hFFFF_FFFE);
        chk("cycle_commit",     cycle,        64'h1_FFFF_FFFE);
        chk("ready_recovery",   ifc.wr_ready, 0);
        chk("pending_cleared",  hi_pending,   0);
        step();
        chk("cycle_commit_p1",  cycle,        64'h1_FFFF_FFFF);
        chk("ready_back",       ifc.wr_ready, 1);

        // Wrap modulo 2^64
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FFFF);
        chk("cycle_all_ones", cycle, '1);
        step();
        chk("cycle_wrap", cycle, 64'd0);

        // Mismatched target: low-only load, pending discarded
        wr(3'd5, 32'd2);
        wr(3'd4, 32'd0);
        chk("instret_full", instret, 64'h2_0000_0000);
        wr(3'd3, 32'd5);
        chk("pending_timeh", hi_pending, 1);
        wr(3'd4, 32'd7);
        chk("instret_low_only", instret, 64'h2_0000_0007);
        chk("pending_dropped",  hi_pending, 0);
        chk("time_upper_kept",  {32'd0, tim[63:32]}, 64'd0);

        // Shadow overwrite, then timecmp = 3
        wr(3'd1, 32'd8);
        wr(3'd7, 32'd0);
        wr(3'd6, 32'd3);
        chk("timecmp_3", timecmp, 64'd3);

        // Restart time at 0 and watch the interrupt rise
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd0);
        chk("time_reset_write", tim, 64'd0);
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i == 11) chk("time_at_11", tim, 2);
            if (i == 12) begin
                chk("time_at_12", tim, 3);
                chk("irq_at_12",  irq, 0);
            end
            if (i == 13) chk("irq_at_13", irq, 1);
        end

        // Move timecmp far away: interrupt falls one cycle after commit
        wr(3'd7, 32'd1);
        wr(3'd6, 32'd0);
        chk("timecmp_far",     timecmp, 64'h1_0000_0000);
        chk("irq_commit_edge", irq,     1);
        step();
        chk("irq_fallen",      irq,     0);

        // Irregular retirement
        for (int i = 0; i < 30; i++) begin
            retire = 1'($urandom_range(0, 1));
            step();
        end

        // Write vs increment with continuous retire
        retire = 1'b1;
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd100);
        chk("instret_write_wins", instret, 64'd100);
        step();
        chk("instret_resumes",    instret, 64'd101);

        // Reset while a high half is pending
        wr(3'd3, 32'd9);
        chk("pending_before_rst", hi_pending, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_pending", hi_pending,   0);
        chk("rst_cycle",   cycle,        64'd0);
        chk("rst_time",    tim,          64'd0);
        chk("rst_instret", instret,      64'd0);
        chk("rst_timecmp", timecmp,      '1);
        chk("rst_irq",     irq,          0);
        chk("rst_ready",   ifc.wr_ready, 0);
        retire = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        retire = 1'b1;
        repeat (3) step();
        wr(3'd2, 32'd5);
        chk("time_low_after_rst", tim, 64'd5);
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
